// File: rtl/dc_vlc_bit_packer.sv
// -----------------------------------------------------------------------------
// dc_vlc_bit_packer
//
// Packs variable-length codewords from the DC coefficient entropy encoder into
// a contiguous MSB-first bitstream. Complete 32-bit words go out on a
// valid/ready port to the slice writer. A flush request pads the last partial
// word with zeros so the slice ends on a word boundary.
//
// Optional feature macro: BIT_PACKER_BYTE_COUNT_EN
//   When defined, o_byte_count exists and counts emitted bytes (+4 per output
//   handshake, wraps at 2^32, cleared only by reset).
//
// Ports:
//   clk           clock
//   reset_n       asynchronous active-low reset
//   i_in_valid    codeword present
//   o_in_ready    packer accepts a codeword this cycle
//   i_in_code     codeword, right-aligned; only the low i_in_len bits are used
//   i_in_len      codeword length 0..24 (25..31 treated as 24)
//   i_flush       single-cycle request to pad and emit the last partial word
//   o_out_valid   o_out_data holds a packed word
//   i_out_ready   consumer takes the word
//   o_out_data    packed word, first stream bit in bit 31
//   o_flush_done  one-cycle pulse when a flush has completed
//   o_byte_count  bytes emitted since reset (BIT_PACKER_BYTE_COUNT_EN only)
// -----------------------------------------------------------------------------
module dc_vlc_bit_packer #(
    parameter int MAX_LEN = 24,
    parameter int WORD_W  = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [MAX_LEN-1:0]  i_in_code,
    input  logic [4:0]          i_in_len,
    input  logic                i_flush,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [WORD_W-1:0]   o_out_data,
    output logic                o_flush_done
`ifdef BIT_PACKER_BYTE_COUNT_EN
    ,
    output logic [31:0]         o_byte_count
`endif
);

    // The buffer holds at most one partial word (31 bits) plus one maximal
    // codeword, because accepts stop as soon as a full word is buffered.
    localparam int BUF_W  = WORD_W + MAX_LEN;
    localparam int FILL_W = $clog2(BUF_W);

    localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(WORD_W);
    localparam logic [FILL_W-1:0] ZERO_FILL = '0;
    localparam logic [4:0]        LEN_MAX   = 5'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Registered state
    state_t              r_state;
    logic [BUF_W-1:0]    r_buf;
    logic [FILL_W-1:0]   r_fill;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [WORD_W-1:0]   r_out_data;
    logic                r_flush_done;

    // Next-state values
    state_t              w_state_next;
    logic [BUF_W-1:0]    w_buf_next;
    logic [FILL_W-1:0]   w_fill_next;
    logic                w_in_ready_next;
    logic                w_out_valid_next;
    logic [WORD_W-1:0]   w_out_data_next;
    logic                w_flush_done_next;

    // Codeword alignment
    logic [4:0]          w_len;
    logic [MAX_LEN-1:0]  w_mask;
    logic [MAX_LEN-1:0]  w_code;
    logic [BUF_W-1:0]    w_ins;
    logic                w_accept;
    logic                w_can_load;
    logic                w_handshake;
    logic                w_full_word;

    assign w_len  = (i_in_len > LEN_MAX) ? LEN_MAX : i_in_len;
    // Shift of an all-ones field by MAX_LEN yields zero, so len 0 masks all.
    assign w_mask = {MAX_LEN{1'b1}} >> (LEN_MAX - w_len);
    assign w_code = i_in_code & w_mask;
    // Left-justify the codeword at the buffer MSB, then drop it just below
    // the current fill. Bits below the fill are always zero, so OR appends.
    assign w_ins  = ({w_code, {WORD_W{1'b0}}} << (LEN_MAX - w_len)) >> r_fill;

    assign w_accept    = i_in_valid && r_in_ready;
    assign w_can_load  = !r_out_valid || i_out_ready;
    assign w_handshake = r_out_valid && i_out_ready;
    assign w_full_word = (r_fill >= WORD_FILL);

    always_comb begin
        w_state_next      = r_state;
        w_buf_next        = r_buf;
        w_fill_next       = r_fill;
        w_out_valid_next  = w_handshake ? 1'b0 : r_out_valid;
        w_out_data_next   = r_out_data;
        w_flush_done_next = 1'b0;

        case (r_state)
            ST_RUN: begin
                // in_ready implies fill < 32, so accept and extract never
                // coincide.
                if (w_accept) begin
                    w_buf_next  = r_buf | w_ins;
                    w_fill_next = r_fill + FILL_W'(w_len);
                end else if (w_full_word && w_can_load) begin
                    w_out_data_next  = r_buf[BUF_W-1 -: WORD_W];
                    w_out_valid_next = 1'b1;
                    w_buf_next       = r_buf << WORD_W;
                    w_fill_next      = r_fill - WORD_FILL;
                end
                if (i_flush) begin
                    w_state_next = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                if (w_full_word && w_can_load) begin
                    w_out_data_next  = r_buf[BUF_W-1 -: WORD_W];
                    w_out_valid_next = 1'b1;
                    w_buf_next       = r_buf << WORD_W;
                    w_fill_next      = r_fill - WORD_FILL;
                end else if ((r_fill != ZERO_FILL) && w_can_load) begin
                    // Partial tail: bits below the fill are already zero,
                    // which provides the padding.
                    w_out_data_next  = r_buf[BUF_W-1 -: WORD_W];
                    w_out_valid_next = 1'b1;
                    w_buf_next       = '0;
                    w_fill_next      = ZERO_FILL;
                end else if ((r_fill == ZERO_FILL) && w_can_load) begin
                    w_state_next      = ST_DONE;
                    w_flush_done_next = 1'b1;
                end
            end

            ST_DONE: begin
                w_state_next = ST_RUN;
            end

            default: begin
                w_state_next = ST_RUN;
            end
        endcase

        w_in_ready_next = (w_state_next == ST_RUN) && (w_fill_next < WORD_FILL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_RUN;
            r_buf        <= '0;
            r_fill       <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_buf        <= w_buf_next;
            r_fill       <= w_fill_next;
            r_in_ready   <= w_in_ready_next;
            r_out_valid  <= w_out_valid_next;
            r_out_data   <= w_out_data_next;
            r_flush_done <= w_flush_done_next;
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_out_valid  = r_out_valid;
    assign o_out_data   = r_out_data;
    assign o_flush_done = r_flush_done;

`ifdef BIT_PACKER_BYTE_COUNT_EN
    logic [31:0] r_byte_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_count <= '0;
        end else if (w_handshake) begin
            r_byte_count <= r_byte_count + 32'd4;
        end
    end

    assign o_byte_count = r_byte_count;
`endif

endmodule

// File: tb/tb_dc_vlc_bit_packer.sv
`timescale 1ns/1ps
module tb_dc_vlc_bit_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [23:0] i_in_code;
    logic [4:0]  i_in_len;
    logic        i_flush;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_out_data;
    logic        o_flush_done;
`ifdef BIT_PACKER_BYTE_COUNT_EN
    logic [31:0] o_byte_count;
`endif

    always #5 clk = ~clk;

    dc_vlc_bit_packer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_in_code    (i_in_code),
        .i_in_len     (i_in_len),
        .i_flush      (i_flush),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_data   (o_out_data),
        .o_flush_done (o_flush_done)
`ifdef BIT_PACKER_BYTE_COUNT_EN
        ,
        .o_byte_count (o_byte_count)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the stream as a plain queue of bits.
    bit          mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          hs_count = 0;

    function automatic void model_pop_word();
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 32; k++) w = {w[30:0], mq.pop_front()};
        exp_q.push_back(w);
    endfunction

    function automatic void model_push(input logic [23:0] code, input logic [4:0] len);
        int n;
        n = (len > 5'd24) ? 24 : int'(len);
        for (int b = n - 1; b >= 0; b--) mq.push_back(code[b]);
        while (mq.size() >= 32) model_pop_word();
    endfunction

    function automatic void model_flush();
        if (mq.size() > 0) begin
            while (mq.size() < 32) mq.push_back(1'b0);
            model_pop_word();
        end
    endfunction

    function automatic void clear_model();
        mq.delete();
        exp_q.delete();
        got_q.delete();
    endfunction

    // Inputs change 1 ns after the rising edge, so the falling edge sees the
    // values that the next rising edge will act on.
    always @(negedge clk) begin
        if (reset_n) begin
            if (i_in_valid && o_in_ready) model_push(i_in_code, i_in_len);
            if (i_flush) model_flush();
            if (o_out_valid && i_out_ready) begin
                got_q.push_back(o_out_data);
                hs_count++;
            end
        end
    end

    task automatic send_code(input logic [23:0] c, input logic [4:0] l);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        i_in_valid = 1'b1;
        i_in_code  = c;
        i_in_len   = l;
        while (!acc && guard < 100) begin
            @(negedge clk);
            acc = o_in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        i_in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1 within 100 cycles", o_in_ready);
        end
    endtask

    task automatic do_flush();
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if (o_flush_done) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        i_in_valid  = 1'b0;
        i_in_code   = '0;
        i_in_len    = '0;
        i_flush     = 1'b0;
        i_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 0", o_in_ready); end
        n_cmp++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", o_out_valid); end
        n_cmp++; if (o_out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %08h want 00000000", o_out_data); end
        n_cmp++; if (o_flush_done !== 1'b0) begin n_fail++; $display("FAIL reset_flush_done: got %0b want 0", o_flush_done); end
`ifdef BIT_PACKER_BYTE_COUNT_EN
        n_cmp++; if (o_byte_count !== 32'h0) begin n_fail++; $display("FAIL reset_byte_count: got %0d want 0", o_byte_count); end
`endif
        reset_n = 1'b1;
        clear_model();
        hs_count = 0;
        @(posedge clk);
        #1;
        n_cmp++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %0b want 1", o_in_ready); end
        $display("test_reset: done");
    endtask

    task automatic test_pack_bytes();
        clear_model();
        i_out_ready = 1'b1;
        send_code(24'h0000A5, 5'd8);
        send_code(24'h00003C, 5'd8);
        send_code(24'h0000FF, 5'd8);
        send_code(24'h000001, 5'd8);
        n_cmp++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL bytes_early_valid: got %0b want 0", o_out_valid); end
        @(posedge clk);
        #1;
        n_cmp++; if (o_out_valid !== 1'b1) begin n_fail++; $display("FAIL bytes_valid: got %0b want 1", o_out_valid); end
        n_cmp++; if (o_out_data !== 32'hA53CFF01) begin n_fail++; $display("FAIL bytes_data: got %08h want A53CFF01", o_out_data); end
        @(posedge clk);
        #1;
        n_cmp++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL bytes_valid_clear: got %0b want 0", o_out_valid); end
        n_cmp++; if (got_q.size() != 1) begin n_fail++; $display("FAIL bytes_count: got %0d words want 1", got_q.size()); end
        $display("test_pack_bytes: word %08h", o_out_data);
    endtask

    task automatic test_flush_24_16();
        int cyc;
        clear_model();
        i_out_ready = 1'b1;
        send_code(24'h123456, 5'd24);
        send_code(24'hFFABCD, 5'd16);   // stray upper bits must be masked
        do_flush();
        wait_done(cyc);
        n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL f2416_done_cycle: got %0d want 2", cyc); end
        n_cmp++; if (got_q.size() != 2) begin n_fail++; $display("FAIL f2416_count: got %0d words want 2", got_q.size()); end
        if (got_q.size() == 2) begin
            n_cmp++; if (got_q[0] !== 32'h123456AB) begin n_fail++; $display("FAIL f2416_w0: got %08h want 123456AB", got_q[0]); end
            n_cmp++; if (got_q[1] !== 32'hCD000000) begin n_fail++; $display("FAIL f2416_w1: got %08h want CD000000", got_q[1]); end
        end
        @(posedge clk);
        #1;
        n_cmp++; if (o_flush_done !== 1'b0) begin n_fail++; $display("FAIL f2416_pulse_width: got %0b want 0", o_flush_done); end
        n_cmp++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL f2416_ready_after: got %0b want 1", o_in_ready); end
        $display("test_flush_24_16: %0d words, done after %0d cycles", got_q.size(), cyc);
    endtask

    task automatic test_len0();
        int cyc;
        clear_model();
        i_out_ready = 1'b1;
        send_code(24'hFFFFFF, 5'd3);
        send_code(24'h000000, 5'd0);
        do_flush();
        wait_done(cyc);
        n_cmp++; if (cyc != 2) begin n_fail++; $display("FAIL len0_done_cycle: got %0d want 2", cyc); end
        n_cmp++; if (got_q.size() != 1) begin n_fail++; $display("FAIL len0_count: got %0d words want 1", got_q.size()); end
        if (got_q.size() == 1) begin
            n_cmp++; if (got_q[0] !== 32'hE0000000) begin n_fail++; $display("FAIL len0_word: got %08h want E0000000", got_q[0]); end
        end
        $display("test_len0: %0d words", got_q.size());
    endtask

    task automatic test_backpressure();
        logic [15:0] c[4];
        logic [31:0] w0;
        logic [31:0] w1;
        clear_model();
        for (int i = 0; i < 4; i++) c[i] = 16'($urandom);
        w0 = {c[0], c[1]};
        w1 = {c[2], c[3]};
        i_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_code({8'h00, c[i]}, 5'd16);
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (o_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", k, o_in_ready); end
            n_cmp++; if (o_out_valid !== 1'b1 || o_out_data !== w0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got valid=%0b data=%08h want valid=1 data=%08h", k, o_out_valid, o_out_data, w0);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL bp_no_handshake: got %0d words want 0", got_q.size()); end
        i_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (got_q.size() != 2) begin n_fail++; $display("FAIL bp_count: got %0d words want 2", got_q.size()); end
        if (got_q.size() == 2) begin
            n_cmp++; if (got_q[0] !== w0) begin n_fail++; $display("FAIL bp_w0: got %08h want %08h", got_q[0], w0); end
            n_cmp++; if (got_q[1] !== w1) begin n_fail++; $display("FAIL bp_w1: got %08h want %08h", got_q[1], w1); end
        end
        n_cmp++; if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %0b want 1", o_in_ready); end
        $display("test_backpressure: words %08h %08h", w0, w1);
    endtask

    task automatic test_flush_empty();
        clear_model();
        i_out_ready = 1'b1;
        do_flush();
        n_cmp++; if (o_flush_done !== 1'b0) begin n_fail++; $display("FAIL fe_done_c1: got %0b want 0", o_flush_done); end
        @(posedge clk);
        #1;
        n_cmp++; if (o_flush_done !== 1'b1) begin n_fail++; $display("FAIL fe_done_c2: got %0b want 1", o_flush_done); end
        @(posedge clk);
        #1;
        n_cmp++; if (o_flush_done !== 1'b0) begin n_fail++; $display("FAIL fe_done_c3: got %0b want 0", o_flush_done); end
        n_cmp++; if (got_q.size() != 0 || o_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL fe_no_word: got %0d words valid=%0b want 0 words valid=0", got_q.size(), o_out_valid);
        end
        $display("test_flush_empty: done");
    endtask

    task automatic test_reset_mid();
        logic [7:0]  b[4];
        logic [31:0] w;
        clear_model();
        i_out_ready = 1'b1;
        send_code(24'($urandom), 5'd12);
        send_code(24'($urandom), 5'd8);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (o_in_ready !== 1'b0 || o_out_valid !== 1'b0 || o_out_data !== 32'h0 || o_flush_done !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got ready=%0b valid=%0b data=%08h done=%0b want 0 0 00000000 0",
                               o_in_ready, o_out_valid, o_out_data, o_flush_done);
        end
        repeat (2) @(posedge clk);
        #1;
        clear_model();
        hs_count = 0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        w = {b[0], b[1], b[2], b[3]};
        for (int i = 0; i < 4; i++) send_code({16'h0, b[i]}, 5'd8);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (got_q.size() != 1) begin n_fail++; $display("FAIL mid_count: got %0d words want 1", got_q.size()); end
        if (got_q.size() == 1) begin
            n_cmp++; if (got_q[0] !== w) begin n_fail++; $display("FAIL mid_word: got %08h want %08h", got_q[0], w); end
        end
        $display("test_reset_mid: word %08h", w);
    endtask

`ifdef BIT_PACKER_BYTE_COUNT_EN
    // Continues straight after test_reset_mid, which left one handshake.
    task automatic test_byte_count();
        for (int i = 0; i < 8; i++) send_code(24'($urandom_range(0, 255)), 5'd8);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (o_byte_count !== 32'd12) begin n_fail++; $display("FAIL byte_count: got %0d want 12", o_byte_count); end
        $display("test_byte_count: %0d", o_byte_count);
    endtask
`endif

    task automatic test_random();
        int cyc;
        int n;
        clear_model();
        for (int t = 0; t < 800; t++) begin
            i_out_ready = ($urandom_range(0, 3) != 0);
            i_in_valid  = $urandom_range(0, 1) != 0;
            i_in_code   = 24'($urandom);
            i_in_len    = 5'($urandom_range(0, 31));
            @(posedge clk);
            #1;
        end
        i_in_valid  = 1'b0;
        i_out_ready = 1'b1;
        do_flush();
        wait_done(cyc);
        n_cmp++; if (cyc < 0) begin n_fail++; $display("FAIL rand_done: got no flush_done within 300 cycles want a pulse"); end
        n_cmp++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rand_word[%0d]: got %08h want %08h", i, got_q[i], exp_q[i]);
            end
        end
`ifdef BIT_PACKER_BYTE_COUNT_EN
        n_cmp++; if (o_byte_count !== 32'(hs_count * 4)) begin n_fail++; $display("FAIL rand_byte_count: got %0d want %0d", o_byte_count, hs_count * 4); end
`endif
        $display("test_random: %0d words compared", n);
    endtask

    initial begin
        test_reset();
        test_pack_bytes();
        test_flush_24_16();
        test_len0();
        test_backpressure();
        test_flush_empty();
        test_reset_mid();
`ifdef BIT_PACKER_BYTE_COUNT_EN
        test_byte_count();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
